axis_zmod_dac: RTL and testbench
================================

Name: axis_zmod_dac

Overview:
- AXI4-Stream sink driving the Zmod DAC interleaved DDR data bus; the transmit-side counterpart of the Zmod ADC capture path.
- Each accepted 32-bit beat carries two signed 16-bit samples: channel A in [15:0], channel B in [31:16].
- Each sample is saturated to DAC width, registered, and launched through ODDR primitives: A on the rising edge, B on the falling edge.
- Owns the DAC reset/startup sequencing and counts stream underruns.

Parameters:
- DAC_DATA_WIDTH, 14, DAC bus width per sample (signed two's complement).
- AXIS_TDATA_WIDTH, 32, stream width; two 16-bit samples per beat.
- RST_CYCLES, 16, cycles dac_rst is held high after reset release.
- SETTLE_CYCLES, 64, cycles after dac_rst release before accepting data.

Ports:
- aclk  in  1  sample clock; one beat consumed per cycle in RUN.
- aresetn  in  1  asynchronous active-low reset.
- cfg_enable  in  1  stream enable; sampled in RUN only.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  packed samples {B, A}.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- dac_clk  out  1  forwarded DAC clock, ODDR D1=1, D2=0.
- dac_data  out  DAC_DATA_WIDTH  DDR data bus.
- dac_rst  out  1  DAC reset, active high.
- sts_running  out  1  high in RUN state.
- sts_underrun  out  32  saturating underrun counter.

Behaviour:
- Clock and reset: single clock domain (aclk); aresetn is asynchronous, active-low.
- Reset values (aresetn low):
  - state = HOLD; dac_rst = 1; s_axis_tready = 0; sts_running = 0.
  - sts_underrun = 0; sample registers A = B = 0, so the bus drives midscale 0.
  - ODDR R pins are driven from the internal reset.
- FSM (one cycle counter, reloaded on each state entry):
  - HOLD: dac_rst = 1. After RST_CYCLES cycles -> SETTLE.
  - SETTLE: dac_rst = 0, samples forced to 0. After SETTLE_CYCLES cycles -> RUN.
  - RUN: sts_running = 1; s_axis_tready = cfg_enable (combinational from the registered state and cfg_enable). RUN is left only via reset.
- Reset mid-operation: asynchronously returns to HOLD with all reset values; the full startup sequence repeats.
- Handshake: a beat is accepted when tvalid && tready. tready never depends on tvalid.
- Data path in RUN with cfg_enable = 1:
  - accept: A_reg <= sat(tdata[15:0]); B_reg <= sat(tdata[31:16]).
  - tvalid low: A_reg = B_reg = 0 and sts_underrun increments, saturating at 0xFFFFFFFF (no wrap).
- Data path in RUN with cfg_enable = 0: tready = 0, registers load 0, no underrun count.
- sat(): 16-bit signed input to DAC_DATA_WIDTH signed output.
  - x > 2^(W-1)-1 -> 2^(W-1)-1.
  - x < -2^(W-1) -> -2^(W-1).
  - otherwise x[W-1:0].
- ODDR configuration: DDR_CLK_EDGE = SAME_EDGE; D1 = A_reg[j], D2 = B_reg[j]; CE = 1.
- Latency: beat accepted at edge k -> registers updated at edge k. ODDR captures at edge k+1, so A appears on dac_data in the high phase after edge k+1 and B in the following low phase.
- Midscale guarantee: dac_data carries 0 in HOLD, in SETTLE, during underrun and while disabled. Samples are never repeated.
- sts_underrun: readable at any time; cleared only by reset.

Test Plan:
- Startup: release aresetn with cfg_enable = 1, tvalid = 1.
  - dac_rst high exactly 16 cycles, then low; tready low for 64 further cycles.
  - sts_running and tready rise on cycle 81; dac_data = 0 throughout.
- Saturation: beats 0x7FFF_8000, 0x0123_FEDC, 0x1FFF_E000.
  - A/B on the bus: 0x2000/0x1FFF, 0x3EDC/0x0123, 0x2000/0x1FFF.
  - Edge latency exactly as specified.
- Underrun: in RUN, drop tvalid for 5 cycles, then resume.
  - Bus shows 0 for those 5 sample pairs; sts_underrun = 5; the next beat appears correctly.
- Disable: cfg_enable = 0 for 10 cycles with tvalid = 1.
  - tready = 0, no beats consumed, bus = 0, sts_underrun unchanged.
- Counter saturation: force sts_underrun near 0xFFFFFFFE, hold tvalid low 4 cycles -> stays at 0xFFFFFFFF.
- Mid-stream reset: pulse aresetn low for 1 ns while streaming.
  - Immediate dac_rst = 1, tready = 0, bus = 0, counter = 0; full 16 + 64 sequence repeats.

Source files
------------

// File: rtl/axis_zmod_dac.sv
// AXI4-Stream sink feeding the Zmod DAC DDR bus: A on rise, B on fall.
// Ports: aclk/aresetn, cfg_enable, s_axis_*, dac_clk/data/rst, sts_*.

module zmod_oddr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q1_q;
  logic [W-1:0] q2_q;

  // Both halves are captured on the rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d1_i;
      q2_q <= d2_i;
    end
  end

  assign q_o = clk_i ? q1_q : q2_q;

endmodule

module axis_zmod_dac #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int RST_CYCLES       = 16,
  parameter int SETTLE_CYCLES    = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic                        dac_clk,
  output logic [DAC_DATA_WIDTH-1:0]   dac_data,
  output logic                        dac_rst,
  output logic                        sts_running,
  output logic [31:0]                 sts_underrun
);

  localparam int W = DAC_DATA_WIDTH;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));
  localparam logic [W-1:0] WMAX = W'(SMAX);
  localparam logic [W-1:0] WMIN = W'(SMIN);
  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SET_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD,
    SETTLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [31:0]   urun_q, urun_d;

  logic run;
  logic take;
  logic starve;

  function automatic logic [W-1:0] sat(input logic [15:0] x);
    int xi;
    xi = int'($signed(x));
    if (xi > SMAX) return WMAX;
    if (xi < SMIN) return WMIN;
    return x[W-1:0];
  endfunction

  assign run           = (state_q == RUN);
  assign s_axis_tready = run && cfg_enable;
  assign take          = s_axis_tready && s_axis_tvalid;
  assign starve        = s_axis_tready && !s_axis_tvalid;
  assign dac_rst       = (state_q == HOLD);
  assign sts_running   = run;
  assign sts_underrun  = urun_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SET_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // Anything but an accepted beat drives midscale; samples never repeat.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    urun_d = urun_q;
    unique case (1'b1)
      take: begin
        a_d = sat(s_axis_tdata[15:0]);
        b_d = sat(s_axis_tdata[31:16]);
      end
      starve: begin
        if (urun_q != '1) urun_d = urun_q + 32'd1;
      end
      default: begin
        a_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HOLD;
      cnt_q   <= RST_LOAD;
      a_q     <= '0;
      b_q     <= '0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      urun_q  <= urun_d;
    end
  end

  zmod_oddr #(.W(W)) u_data (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .d1_i   (a_q),
    .d2_i   (b_q),
    .q_o    (dac_data)
  );

  zmod_oddr #(.W(1)) u_clk (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .d1_i   (1'b1),
    .d2_i   (1'b0),
    .q_o    (dac_clk)
  );

endmodule

// File: tb/tb_axis_zmod_dac.sv
// Directed bench for axis_zmod_dac: startup, saturation, underrun,
// disable, counter saturation and mid-stream reset.

module tb_axis_zmod_dac;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_enable;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        dac_clk;
  logic [13:0] dac_data;
  logic        dac_rst;
  logic        sts_running;
  logic [31:0] sts_underrun;

  int errors = 0;
  int checks = 0;

  logic [13:0] hi_s, lo_s;
  logic        ck_hi, ck_lo;

  always #5 aclk = ~aclk;

  axis_zmod_dac dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dac_clk       (dac_clk),
    .dac_data      (dac_data),
    .dac_rst       (dac_rst),
    .sts_running   (sts_running),
    .sts_underrun  (sts_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample high phase, then low phase; return in low phase.
  task automatic cyc();
    @(posedge aclk);
    #2;
    hi_s  = dac_data;
    ck_hi = dac_clk;
    @(negedge aclk);
    #2;
    lo_s  = dac_data;
    ck_lo = dac_clk;
  endtask

  task automatic bus(input string tag, input logic [13:0] ea,
                     input logic [13:0] eb);
    chk({tag, "_A"}, 32'(hi_s), 32'(ea));
    chk({tag, "_B"}, 32'(lo_s), 32'(eb));
  endtask

  task automatic startup();
    for (int n = 1; n <= 80; n++) begin
      cyc();
      chk("su_rst", 32'(dac_rst), 32'(n < 16));
      chk("su_rdy", 32'(s_axis_tready), 32'(n >= 80));
      chk("su_run", 32'(sts_running), 32'(n >= 80));
      bus("su_bus", 14'h0, 14'h0);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    cfg_enable    = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h7FFF_8000;
    #23;
    chk("rst_dac_rst", 32'(dac_rst), 32'd1);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_running", 32'(sts_running), 32'd0);
    chk("rst_underrun", sts_underrun, 32'd0);
    chk("rst_bus", 32'(dac_data), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    startup();

    // Saturation beats
    cyc();
    s_axis_tdata = 32'h0123_FEDC;
    cyc();
    bus("sat0", 14'h2000, 14'h1FFF);
    chk("dclk_hi", 32'(ck_hi), 32'd1);
    chk("dclk_lo", 32'(ck_lo), 32'd0);
    s_axis_tdata = 32'h1FFF_E000;
    cyc();
    bus("sat1", 14'h3EDC, 14'h0123);
    s_axis_tvalid = 1'b0;
    cyc();
    bus("sat2", 14'h2000, 14'h1FFF);

    // Underrun: five starved edges
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus("urun_bus", 14'h0, 14'h0);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0456_0FA0;
    cyc();
    bus("urun_bus", 14'h0, 14'h0);
    chk("urun_cnt", sts_underrun, 32'd5);
    s_axis_tdata = 32'h0001_3FFF;
    cyc();
    bus("resume", 14'h0FA0, 14'h0456);

    // Disable for ten cycles
    cfg_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("dis_tready", 32'(s_axis_tready), 32'd0);
      if (i == 0) bus("dis_last", 14'h1FFF, 14'h0001);
      else bus("dis_bus", 14'h0, 14'h0);
    end
    chk("dis_cnt", sts_underrun, 32'd5);
    cfg_enable   = 1'b1;
    s_axis_tdata = 32'h8000_7FFF;
    cyc();
    bus("reen_gap", 14'h0, 14'h0);
    cyc();
    bus("reen", 14'h1FFF, 14'h2000);

    // Counter saturation
    force dut.urun_q = 32'hFFFF_FFFE;
    cyc();
    release dut.urun_q;
    chk("csat_pre", sts_underrun, 32'hFFFF_FFFE);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("csat", sts_underrun, 32'hFFFF_FFFF);
    end

    // Mid-stream reset
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0100_0200;
    cyc();
    cyc();
    bus("pre_rst", 14'h0200, 14'h0100);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_dac_rst", 32'(dac_rst), 32'd1);
    chk("mid_tready", 32'(s_axis_tready), 32'd0);
    chk("mid_running", 32'(sts_running), 32'd0);
    chk("mid_underrun", sts_underrun, 32'd0);
    chk("mid_bus", 32'(dac_data), 32'd0);
    aresetn = 1'b1;
    s_axis_tdata = 32'h7FFF_8000;

    startup();
    cyc();
    cyc();
    bus("restart", 14'h2000, 14'h1FFF);
    chk("restart_cnt", sts_underrun, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
